move_input_ctrl: RTL
====================

Name: move_input_ctrl

Overview:
Parametrised front end that turns N raw push-buttons into accepted move commands for the game FSM. It replaces the divided-clock scheme with a single-clock design: a divider-generated clock-enable tick, 2-FF synchronisers, per-channel debounce, press/auto-repeat event generation and a pending-request queue. Commands are delivered over a valid/ready handshake with a saturating drop counter. It sits between the board buttons and the game state machine, all on ClkPort.

Parameters:
N_BTN, 4, number of button channels (≥1); index 0 is highest priority.
TICK_DIV, 100000, ClkPort cycles per tick (≥2); 100000 gives 1 ms at 100 MHz.
DEB_TICKS, 10, consecutive ticks a synchronised level must differ from the stable level before it is accepted (≥1).
REPEAT_TICKS, 0, auto-repeat period in ticks while a button is held; 0 disables repeat.
DIR_W, max(1,clog2(N_BTN)), derived width of move_dir.

Ports:
ClkPort  in  1  system clock, 100 MHz
rst  in  1  asynchronous, active-high reset
btn_raw  in  N_BTN  raw asynchronous button levels
move_ready  in  1  game FSM accepts the offered move
move_valid  out  1  move offered
move_dir  out  DIR_W  channel index of the offered move
btn_level  out  N_BTN  debounced stable levels
tick  out  1  one-cycle clock-enable pulse every TICK_DIV cycles
drop_cnt  out  8  saturating count of events lost to an already-pending channel

Behaviour:
- Reset (async, active-high, rst): all registers clear; tick=0, move_valid=0, move_dir=0, btn_level=0, drop_cnt=0, pending=0, FSM=IDLE.
- Tick divider:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly the cycle in which the counter equals TICK_DIV-1; period is exactly TICK_DIV.
- Synchroniser: 2 flops per channel; every downstream block sees only sync[i].
- Debounce, per channel, evaluated only on tick cycles:
  - If sync≠stable, deb_cnt increments.
  - When deb_cnt reaches DEB_TICKS-1 while sync still differs, stable<=sync and deb_cnt<=0.
  - If sync==stable, deb_cnt<=0.
  - A glitch shorter than DEB_TICKS ticks never changes stable.
  - btn_level=stable.
- Event generation:
  - A press event for channel i is a 0→1 transition of stable[i]; it occurs in a tick cycle.
  - If REPEAT_TICKS>0: while stable[i]=1, the per-channel rep_cnt counts ticks. Every REPEAT_TICKS ticks after the press, it emits a repeat event and reloads. rep_cnt clears on release.
  - If REPEAT_TICKS=0, rep_cnt is not implemented.
- Pending register, N_BTN bits:
  - An event sets pending[i].
  - An event arriving while pending[i]=1 (and the bit is not being cleared this cycle) is dropped: drop_cnt+1, saturating at 255.
- Handshake FSM:
  - IDLE: if pending≠0, move_dir<=lowest set index, move_valid<=1, go to OFFER. This gives one cycle of latency from pending set to valid.
  - OFFER: move_valid and move_dir are held stable until move_ready=1. Lower-index events arriving meanwhile do not change move_dir.
  - On valid&&ready: pending[move_dir] clears, move_valid<=0, go to IDLE.
  - Peak throughput is 1 move per 2 cycles.
- Simultaneous events and rst:
  - Event on the granted channel in the accept cycle: set wins, the bit stays pending, no drop counted.
  - Events on other channels in the same cycle set normally.
  - Simultaneous presses on multiple channels are all queued and served lowest index first.
  - rst mid-offer drops the offer immediately (move_valid=0); pending events are lost.
- move_ready while move_valid=0 is ignored.

Test Plan:
Use TICK_DIV=4, DEB_TICKS=3, REPEAT_TICKS=0 unless stated.
1. Reset, then free-run 20 cycles → tick high on cycles 3, 7, 11, 15, 19 after rst release; all other outputs 0.
2. Press btn_raw[2] clean for 20 cycles, move_ready=1 → btn_level[2] rises after 2 sync cycles + 3 ticks; move_valid pulses one cycle with move_dir=2; exactly 1 move total.
3. btn_raw[1] glitch high for 2 ticks, then low → btn_level stays 0, no move_valid, drop_cnt=0.
4. Press channels 3 and 0 on the same tick, move_ready=0 for 10 cycles, then 1 → move_dir=0 held all 10 cycles; then move_dir=3 offered; 2 moves total.
5. move_ready=0; press/release channel 1 twice (each accepted by debounce) → 1 pending move, drop_cnt=1; after ready, only one move with move_dir=1.
6. REPEAT_TICKS=8; hold btn_raw[0] for 40 ticks, move_ready=1 → initial move plus one repeat every 8 ticks (≈5 moves); release stops repeats; assert rst mid-offer → move_valid=0 on the same edge.

Source files
------------

// File: rtl/move_input_ctrl.sv
// move_input_ctrl: turns raw push-buttons into move commands for the game FSM.
// Single-clock pipeline: tick divider, 2-FF synchronisers, tick-paced debounce,
// press / auto-repeat events, a per-channel pending bit and a valid/ready offer.
module move_input_ctrl #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 100000,
  parameter int DEB_TICKS    = 10,
  parameter int REPEAT_TICKS = 0,
  parameter int DIR_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             ClkPort,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             move_ready,
  output logic             move_valid,
  output logic [DIR_W-1:0] move_dir,
  output logic [N_BTN-1:0] btn_level,
  output logic             tick,
  output logic [7:0]       drop_cnt
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_TICKS - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [TW-1:0]    div_cnt;
  logic [N_BTN-1:0] sync_q1, sync;
  logic [N_BTN-1:0] stable, stable_nxt;
  logic [DW-1:0]    deb_cnt     [N_BTN];
  logic [DW-1:0]    deb_cnt_nxt [N_BTN];
  logic [N_BTN-1:0] press_evt, rep_evt, evt;
  logic [N_BTN-1:0] pending, pending_nxt, clr_mask, drops;
  logic [DIR_W-1:0] low_idx;
  logic [7:0]       drop_sum;
  logic [8:0]       drop_tot;
  logic [0:0]       state;
  logic             accept;

  // Free-running divider; tick marks the last count of each period.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst)                    div_cnt <= '0;
    else if (div_cnt == TICK_LAST) div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == TICK_LAST);

  // Two-flop synchroniser; nothing downstream looks at btn_raw directly.
  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) begin
      sync_q1 <= '0;
      sync    <= '0;
    end else begin
      sync_q1 <= btn_raw;
      sync    <= sync_q1;
    end
  end

  // Debounce next-state: a level must differ for DEB_TICKS consecutive ticks.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < N_BTN; i++) begin
      deb_cnt_nxt[i] = deb_cnt[i];
      if (tick) begin
        if (sync[i] != stable[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            stable_nxt[i]  = sync[i];
            deb_cnt_nxt[i] = '0;
          end else begin
            deb_cnt_nxt[i] = deb_cnt[i] + 1'b1;
          end
        end else begin
          deb_cnt_nxt[i] = '0;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) begin
      stable <= '0;
      for (int i = 0; i < N_BTN; i++) deb_cnt[i] <= '0;
    end else begin
      stable <= stable_nxt;
      for (int i = 0; i < N_BTN; i++) deb_cnt[i] <= deb_cnt_nxt[i];
    end
  end

  assign btn_level = stable;
  // A press is the tick on which the debounced level goes 0 -> 1.
  assign press_evt = stable_nxt & ~stable;

  generate
    if (REPEAT_TICKS > 0) begin : g_rep
      localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
      localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
      logic [RW-1:0] rep_cnt [N_BTN];

      // A repeat fires every REPEAT_TICKS ticks while the button stays held.
      always_comb begin
        for (int i = 0; i < N_BTN; i++)
          rep_evt[i] = tick && stable[i] && stable_nxt[i] && (rep_cnt[i] == REP_LAST);
      end

      // Repeat counters run on ticks while held and clear on release.
      always_ff @(posedge ClkPort or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < N_BTN; i++) rep_cnt[i] <= '0;
        end else begin
          for (int i = 0; i < N_BTN; i++) begin
            if (!stable_nxt[i])           rep_cnt[i] <= '0;
            else if (tick && stable[i])   rep_cnt[i] <= (rep_cnt[i] == REP_LAST) ? '0 : rep_cnt[i] + 1'b1;
          end
        end
      end
    end else begin : g_no_rep
      assign rep_evt = '0;
    end
  endgenerate

  assign evt      = press_evt | rep_evt;
  assign accept   = move_valid && move_ready;
  assign clr_mask = accept ? (N_BTN'(1) << move_dir) : '0;
  // A new event on the channel being accepted re-arms it rather than dropping.
  assign pending_nxt = (pending & ~clr_mask) | evt;
  assign drops       = evt & pending & ~clr_mask;

  // Lowest pending index wins the next offer; also sums dropped events.
  always_comb begin
    low_idx  = '0;
    drop_sum = '0;
    for (int i = N_BTN - 1; i >= 0; i--)
      if (pending[i]) low_idx = DIR_W'(i);
    for (int i = 0; i < N_BTN; i++)
      drop_sum = drop_sum + 8'(drops[i]);
    drop_tot = {1'b0, drop_cnt} + {1'b0, drop_sum};
  end

  // Pending bits and the saturating drop counter.
  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      pending  <= pending_nxt;
      drop_cnt <= drop_tot[8] ? 8'hFF : drop_tot[7:0];
    end
  end

  // Offer FSM: latch the lowest pending channel and hold it until accepted.
  always_ff @(posedge ClkPort or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      move_valid <= 1'b0;
      move_dir   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pending) begin
            move_dir   <= low_idx;
            move_valid <= 1'b1;
            state      <= OFFER;
          end
        end
        default: begin
          if (move_ready) begin
            move_valid <= 1'b0;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
